iob_cpu_bus_router: RTL and testbench
=====================================

Name: iob_cpu_bus_router

Overview:
- Parametrised successor to the CPU bus split used in the RISC-V core wrapper.
- Accepts the core's native memory interface (valid/instr/addr/wdata/wstrb → rdata/ready) and routes each access to one of N_CH IOb channels, selected by upper address bits.
- Instruction fetches can optionally be forced to channel 0.
- Adds behaviour the previous split did not have: a registered handshake FSM, a per-access timeout, unmapped-address detection and a sticky error flag.

Parameters:
- N_CH, 2, number of IOb channels (1..8).
- SEL_W, 1, address bits used for channel select; taken as cpu_addr_i[ADDR_W-1 -: SEL_W]. Must satisfy 2^SEL_W >= N_CH.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- INSTR_CH0, 1, when 1 every access with cpu_instr_i=1 goes to channel 0 regardless of address.
- TIMEOUT_W, 8, width of the wait counter; an access times out after 2^TIMEOUT_W-1 waiting cycles.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous reset, active-high.
- cke_i  in  1  clock enable; when 0 all state holds.
- cpu_valid_i  in  1  native request valid.
- cpu_instr_i  in  1  request is an instruction fetch.
- cpu_addr_i  in  ADDR_W  request address.
- cpu_wdata_i  in  DATA_W  write data.
- cpu_wstrb_i  in  DATA_W/8  byte strobes; 0 means read.
- cpu_rdata_o  out  DATA_W  read data, valid while cpu_ready_o=1.
- cpu_ready_o  out  1  one-cycle completion pulse.
- ch_valid_o  out  N_CH  per-channel IOb valid.
- ch_addr_o  out  N_CH*ADDR_W  per-channel address; all slices carry the same value.
- ch_wdata_o  out  N_CH*DATA_W  per-channel write data; same value on all slices.
- ch_wstrb_o  out  N_CH*DATA_W/8  per-channel strobes; same value on all slices.
- ch_ready_i  in  N_CH  per-channel request accept.
- ch_rvalid_i  in  N_CH  per-channel read-data valid.
- ch_rdata_i  in  N_CH*DATA_W  per-channel read data.
- err_o  out  1  sticky error flag (timeout or unmapped access).
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset values: cpu_ready_o=0, cpu_rdata_o=0, ch_valid_o=0, ch_addr/wdata/wstrb=0, err_o=0, FSM=IDLE, counter=0.
- All outputs are registered. With cke_i=0, no state or output changes, including err_clr_i handling.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Advances only when cpu_valid_i=1.
  - Captures addr, wdata, wstrb and sel. sel=0 if INSTR_CH0 and cpu_instr_i; otherwise the address field.
  - If sel >= N_CH: cpu_rdata_o=0, set err, go to DONE.
  - Otherwise drive ch_valid_o[sel]=1 and go to REQ.
- REQ:
  - ch_valid_o[sel] held high. Captured fields are stable.
  - On ch_ready_i[sel]=1:
    - Drop valid.
    - If wstrb≠0 (write): go to DONE.
    - Else (read): go to RESP.
  - Otherwise increment the counter.
- RESP:
  - On ch_rvalid_i[sel]=1: latch ch_rdata_i slice sel into cpu_rdata_o and go to DONE.
  - Otherwise increment the counter.
  - rvalid on the same cycle as ready is not expected and is ignored.
- DONE: cpu_ready_o=1 for exactly one cycle, counter cleared, go to IDLE. The next request can be sampled in the following cycle.
- Timeout:
  - If the counter reaches 2^TIMEOUT_W-1 in REQ or RESP: drop ch_valid_o, cpu_rdata_o=0, set err, go to DONE.
  - The counter resets on every state entry to REQ.
- Latency (from the cpu_valid_i sampling edge to the cpu_ready_o pulse):
  - Write with immediate ready: 2 cycles.
  - Read with immediate ready and rvalid one cycle later: 3 cycles.
- Non-selected channels: ch_valid_o stays 0. ch_rvalid_i on any non-selected channel is ignored.
- err_o:
  - Sets on timeout or unmapped access.
  - err_clr_i=1 clears it.
  - Simultaneous set and clear: set wins.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No pulse or valid is emitted.

Test Plan:
- N_CH=2, SEL_W=1: data read at 0x8000_0010, ch1 ready immediately, rvalid+rdata=0x1234_5678 next cycle → ch_valid_o=2'b10 for 1 cycle; cpu_ready_o pulse 3 cycles after sampling; cpu_rdata_o=0x1234_5678; err_o=0.
- Write to 0x0000_0040, wdata=0xCAFE_F00D, wstrb=4'b0011, ch0 ready after 4 wait cycles → ch_valid_o[0] held 5 cycles with stable fields; cpu_ready_o one cycle later; no ch1 activity.
- INSTR_CH0=1, fetch at 0x8000_0000 → routed to ch0 (ch_valid_o=2'b01). Repeat with INSTR_CH0=0 → routed to ch1.
- TIMEOUT_W=4, read on ch1, ready never asserted → ch_valid_o drops after 15 waiting cycles; cpu_ready_o pulses with rdata=0; err_o=1 until err_clr_i pulse; err_clr_i and a new timeout in the same cycle → err_o stays 1.
- N_CH=3, SEL_W=2, access to 0xC000_0000 → no ch_valid_o; cpu_ready_o pulse 1 cycle after sampling; rdata=0; err_o=1.
- arst_i asserted while in RESP → all outputs 0 immediately; a late ch_rvalid_i after reset release produces no cpu_ready_o; the next request completes normally.

Source files
------------

// File: rtl/iob_cpu_bus_router.sv
// Routes the core's native memory interface to one of N_CH IOb channels.
// A registered FSM handles the handshake, the per-access timeout, unmapped accesses and a sticky error.
module iob_cpu_bus_router #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned SEL_W     = 1,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned INSTR_CH0 = 1,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       cke_i,
    input  logic                       cpu_valid_i,
    input  logic                       cpu_instr_i,
    input  logic [ADDR_W-1:0]          cpu_addr_i,
    input  logic [DATA_W-1:0]          cpu_wdata_i,
    input  logic [DATA_W/8-1:0]        cpu_wstrb_i,
    output logic [DATA_W-1:0]          cpu_rdata_o,
    output logic                       cpu_ready_o,
    output logic [N_CH-1:0]            ch_valid_o,
    output logic [N_CH*ADDR_W-1:0]     ch_addr_o,
    output logic [N_CH*DATA_W-1:0]     ch_wdata_o,
    output logic [N_CH*DATA_W/8-1:0]   ch_wstrb_o,
    input  logic [N_CH-1:0]            ch_ready_i,
    input  logic [N_CH-1:0]            ch_rvalid_i,
    input  logic [N_CH*DATA_W-1:0]     ch_rdata_i,
    output logic                       err_o,
    input  logic                       err_clr_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    // Last count value before the wait counter would reach 2^TIMEOUT_W-1.
    localparam logic [TIMEOUT_W-1:0] CntLast = {{(TIMEOUT_W - 1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   ready_q, ready_d;
    logic [N_CH-1:0]        valid_q, valid_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   err_set;

    logic                   sel_ready;
    logic                   sel_rvalid;
    logic [DATA_W-1:0]      sel_rdata;

    always_comb begin
        sel_ready  = 1'b0;
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready  = ch_ready_i[i];
                sel_rvalid = ch_rvalid_i[i];
                sel_rdata  = ch_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_valid_i) begin
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                    wstrb_d = cpu_wstrb_i;
                    sel_d   = (INSTR_CH0 != 0 && cpu_instr_i) ? '0
                                                              : cpu_addr_i[ADDR_W-1 -: SEL_W];
                    cnt_d   = '0;
                    if (32'(sel_d) >= N_CH) begin
                        rdata_d = '0;
                        err_set = 1'b1;
                        ready_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        for (int i = 0; i < int'(N_CH); i++) begin
                            valid_d[i] = (sel_d == SEL_W'(i));
                        end
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (sel_ready) begin
                    valid_d = '0;
                    if (wstrb_q != '0) begin
                        ready_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StResp;
                    end
                end else if (cnt_q == CntLast) begin
                    valid_d = '0;
                    rdata_d = '0;
                    err_set = 1'b1;
                    ready_d = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (sel_rvalid) begin
                    rdata_d = sel_rdata;
                    ready_d = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_set = 1'b1;
                    ready_d = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A new error in the same cycle as a clear request wins.
        err_d = err_set | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            valid_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign cpu_ready_o = ready_q;
    assign ch_valid_o  = valid_q;
    assign ch_addr_o   = {N_CH{addr_q}};
    assign ch_wdata_o  = {N_CH{wdata_q}};
    assign ch_wstrb_o  = {N_CH{wstrb_q}};
    assign err_o       = err_q;

endmodule

// File: tb/tb_iob_cpu_bus_router.sv
// Bench for iob_cpu_bus_router: 3 channels, 2 select bits, 4-bit timeout counter.
// Each access is measured cycle by cycle and compared with expectations derived from the routing rules.
module tb_iob_cpu_bus_router;

    localparam int unsigned NCh  = 3;
    localparam int unsigned SelW = 2;
    localparam int unsigned TW   = 4;
    localparam bit          InstrCh0 = 1'b1;
    localparam int          Tmax = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        arst, cke, cpu_valid, cpu_instr, err_clr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready, err;
    logic [2:0]  ch_valid, ch_ready, ch_rvalid;
    logic [95:0] ch_addr, ch_wdata, ch_rdata;
    logic [11:0] ch_wstrb;

    int checks = 0;
    int failures = 0;

    // Measurements from the most recent access.
    int          m_valid_cyc, m_lat, m_ready_cyc;
    logic [2:0]  m_valid_or;
    logic [31:0] m_rdata;
    logic        m_err, m_stable;

    iob_cpu_bus_router #(
        .N_CH(NCh), .SEL_W(SelW), .ADDR_W(32), .DATA_W(32),
        .INSTR_CH0(InstrCh0 ? 1 : 0), .TIMEOUT_W(TW)
    ) dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke),
        .cpu_valid_i(cpu_valid), .cpu_instr_i(cpu_instr), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
        .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
        .ch_valid_o(ch_valid), .ch_addr_o(ch_addr), .ch_wdata_o(ch_wdata),
        .ch_wstrb_o(ch_wstrb), .ch_ready_i(ch_ready), .ch_rvalid_i(ch_rvalid),
        .ch_rdata_i(ch_rdata), .err_o(err), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: routing and timing derived from the access rules.
    function automatic int exp_ch(input logic instr, input logic [31:0] addr);
        return (InstrCh0 && instr) ? 0 : int'(addr[31:30]);
    endfunction

    function automatic bit exp_timeout(input int ch, input logic [3:0] wstrb,
                                       input int rdy, input int rv);
        int waits;
        if (ch >= int'(NCh)) return 1'b0;
        waits = rdy + ((wstrb == 4'h0) ? rv - 1 : 0);
        return waits >= Tmax;
    endfunction

    function automatic int exp_lat(input int ch, input logic [3:0] wstrb,
                                   input int rdy, input int rv);
        if (ch >= int'(NCh)) return 1;
        if (rdy >= Tmax) return Tmax + 1;
        if (exp_timeout(ch, wstrb, rdy, rv)) return Tmax + 2;
        return rdy + 2 + ((wstrb == 4'h0) ? rv : 0);
    endfunction

    // Drives one access and plays the selected channel (ready after rdy_dly waiting cycles,
    // rvalid rv_dly cycles after acceptance); other channels get random noise.
    task automatic run_access(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int rdy_dly, input int rv_dly,
                              input logic [31:0] rdat);
        int ch, acc_cyc, stop_k;
        ch = exp_ch(instr, addr);
        m_valid_cyc = 0; m_valid_or = '0; m_lat = -1; m_rdata = '0;
        m_err = 1'b0; m_stable = 1'b1; m_ready_cyc = 0;
        acc_cyc = -1; stop_k = 40;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = addr;
        cpu_wdata = wdata; cpu_wstrb = wstrb;
        ch_ready = '0; ch_rvalid = '0;
        @(posedge clk); #1;
        for (int k = 1; k <= stop_k; k++) begin
            if (ch_valid != '0) begin
                m_valid_cyc++;
                m_valid_or |= ch_valid;
                if (ch_addr !== {3{addr}} || ch_wdata !== {3{wdata}} || ch_wstrb !== {3{wstrb}})
                    m_stable = 1'b0;
            end
            if (cpu_ready === 1'b1) begin
                m_ready_cyc++;
                if (m_lat < 0) begin
                    m_lat = k; m_rdata = cpu_rdata; m_err = err;
                    stop_k = k + 2; cpu_valid = 1'b0;
                end
            end
            ch_ready  = 3'($urandom);
            ch_rvalid = 3'($urandom);
            ch_rdata  = {$urandom, $urandom, $urandom};
            if (ch < int'(NCh)) begin
                ch_ready[ch] = 1'b0;
                ch_rvalid[ch] = 1'b0;
                if (ch_valid[ch] && acc_cyc < 0 && m_valid_cyc == rdy_dly + 1) begin
                    ch_ready[ch] = 1'b1;
                    acc_cyc = k;
                end
                if (acc_cyc >= 0 && k == acc_cyc + rv_dly) begin
                    ch_rvalid[ch] = 1'b1;
                    ch_rdata[ch*32 +: 32] = rdat;
                end
            end
            @(posedge clk); #1;
        end
        cpu_valid = 1'b0; ch_ready = '0; ch_rvalid = '0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", cpu_ready); end
        checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", cpu_rdata); end
        checks++; if (ch_valid !== 3'b000) begin failures++; $display("FAIL rst_valid got=%0b exp=0", ch_valid); end
        checks++; if (ch_addr !== 96'h0 || ch_wdata !== 96'h0 || ch_wstrb !== 12'h0) begin
            failures++; $display("FAIL rst_fields got=%0h/%0h/%0h exp=0", ch_addr, ch_wdata, ch_wstrb); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
        @(negedge clk); arst = 1'b0;
    endtask

    task automatic test_read_basic();
        run_access(1'b0, 32'h4000_0010, 32'h0, 4'h0, 0, 1, 32'h1234_5678);
        checks++; if (m_valid_or !== 3'b010 || m_valid_cyc != 1) begin failures++;
            $display("FAIL read_valid got=%0b/%0d exp=010/1", m_valid_or, m_valid_cyc); end
        checks++; if (m_lat != 3) begin failures++; $display("FAIL read_lat got=%0d exp=3", m_lat); end
        checks++; if (m_rdata !== 32'h1234_5678) begin failures++;
            $display("FAIL read_rdata got=%0h exp=12345678", m_rdata); end
        checks++; if (m_err !== 1'b0 || m_ready_cyc != 1) begin failures++;
            $display("FAIL read_err_pulse got=%0b/%0d exp=0/1", m_err, m_ready_cyc); end
    endtask

    task automatic test_write_wait();
        run_access(1'b0, 32'h0000_0040, 32'hCAFE_F00D, 4'b0011, 4, 1, 32'h0);
        checks++; if (m_valid_or !== 3'b001 || m_valid_cyc != 5) begin failures++;
            $display("FAIL write_valid got=%0b/%0d exp=001/5", m_valid_or, m_valid_cyc); end
        checks++; if (m_stable !== 1'b1) begin failures++; $display("FAIL write_fields got=unstable exp=stable"); end
        checks++; if (m_lat != 6) begin failures++; $display("FAIL write_lat got=%0d exp=6", m_lat); end
    endtask

    task automatic test_instr_fetch();
        run_access(1'b1, 32'h8000_0000, 32'h0, 4'h0, 1, 2, 32'h0BAD_F00D);
        checks++; if (m_valid_or !== 3'b001 || m_rdata !== 32'h0BAD_F00D) begin failures++;
            $display("FAIL fetch_ch0 got=%0b/%0h exp=001/badf00d", m_valid_or, m_rdata); end
        run_access(1'b0, 32'h8000_0000, 32'h0, 4'h0, 1, 2, 32'h5555_AAAA);
        checks++; if (m_valid_or !== 3'b100 || m_rdata !== 32'h5555_AAAA) begin failures++;
            $display("FAIL data_ch2 got=%0b/%0h exp=100/5555aaaa", m_valid_or, m_rdata); end
        run_access(1'b1, 32'hC000_0000, 32'h0, 4'h0, 0, 1, 32'h7777_1111);
        checks++; if (m_valid_or !== 3'b001 || m_err !== 1'b0) begin failures++;
            $display("FAIL fetch_override got=%0b/%0b exp=001/0", m_valid_or, m_err); end
    endtask

    task automatic test_unmapped();
        run_access(1'b0, 32'hC000_0000, 32'h0, 4'h0, 0, 1, 32'hFFFF_FFFF);
        checks++; if (m_valid_or !== 3'b000 || m_lat != 1) begin failures++;
            $display("FAIL unmapped_route got=%0b/%0d exp=000/1", m_valid_or, m_lat); end
        checks++; if (m_rdata !== 32'h0 || m_err !== 1'b1) begin failures++;
            $display("FAIL unmapped_err got=%0h/%0b exp=0/1", m_rdata, m_err); end
        pulse_clear();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL unmapped_clear got=%0b exp=0", err); end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 32'h4000_0000, 32'h0, 4'h0, 99, 1, 32'h0);
        checks++; if (m_valid_cyc != Tmax || m_lat != Tmax + 1) begin failures++;
            $display("FAIL tmo_req got=%0d/%0d exp=%0d/%0d", m_valid_cyc, m_lat, Tmax, Tmax + 1); end
        checks++; if (m_rdata !== 32'h0 || m_err !== 1'b1) begin failures++;
            $display("FAIL tmo_req_err got=%0h/%0b exp=0/1", m_rdata, m_err); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%0b exp=1", err); end
        pulse_clear();
        // Clear held through a response-phase timeout: the new error must win.
        @(negedge clk); err_clr = 1'b1;
        run_access(1'b0, 32'h8000_0004, 32'h0, 4'h0, 2, 99, 32'h0);
        checks++; if (m_lat != Tmax + 2 || m_err !== 1'b1) begin failures++;
            $display("FAIL tmo_resp_setwins got=%0d/%0b exp=%0d/1", m_lat, m_err, Tmax + 2); end
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_cleared got=%0b exp=0", err); end
    endtask

    task automatic test_cke();
        run_access(1'b0, 32'hC000_0000, 32'h0, 4'h0, 0, 1, 32'h0);
        @(negedge clk);
        cke = 1'b0; err_clr = 1'b1;
        cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h0000_0100; cpu_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (err !== 1'b1 || ch_valid !== 3'b000 || cpu_ready !== 1'b0) begin failures++;
                $display("FAIL cke_hold got=%0b/%0b/%0b exp=1/000/0", err, ch_valid, cpu_ready); end
        end
        @(negedge clk);
        cpu_valid = 1'b0; err_clr = 1'b0; cke = 1'b1;
        pulse_clear();
    endtask

    task automatic test_reset_mid_op();
        run_access(1'b0, 32'h4000_0008, 32'h0, 4'h0, 0, 1, 32'hA5A5_A5A5);
        @(negedge clk);
        cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h4000_0020;
        cpu_wdata = 32'h1111_2222; cpu_wstrb = 4'h0;
        @(posedge clk); #1;
        ch_ready = 3'b010;
        @(posedge clk); #1;
        ch_ready = 3'b000;
        #2 arst = 1'b1;
        #1;
        checks++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0 || ch_valid !== 3'b000) begin failures++;
            $display("FAIL midrst_out got=%0b/%0h/%0b exp=0/0/000", cpu_ready, cpu_rdata, ch_valid); end
        checks++; if (ch_addr !== 96'h0 || ch_wdata !== 96'h0) begin failures++;
            $display("FAIL midrst_fields got=%0h/%0h exp=0/0", ch_addr, ch_wdata); end
        cpu_valid = 1'b0;
        @(negedge clk); arst = 1'b0;
        ch_rvalid = 3'b010; ch_rdata = {32'h0, 32'hDEAD_BEEF, 32'h0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (cpu_ready !== 1'b0) begin failures++;
                $display("FAIL midrst_late_rvalid got=%0b exp=0", cpu_ready); end
        end
        ch_rvalid = 3'b000;
        run_access(1'b0, 32'h4000_0020, 32'h0, 4'h0, 0, 1, 32'h0F0F_1234);
        checks++; if (m_lat != 3 || m_rdata !== 32'h0F0F_1234) begin failures++;
            $display("FAIL midrst_next got=%0d/%0h exp=3/f0f1234", m_lat, m_rdata); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic        instr;
            logic [31:0] addr, wdata, rdat;
            logic [3:0]  wstrb;
            int          rdy, rv, ch;
            bit          tmo;
            instr = 1'($urandom); addr = $urandom; wdata = $urandom; rdat = $urandom;
            wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            rdy = $urandom_range(0, 5); rv = $urandom_range(1, 5);
            ch = exp_ch(instr, addr);
            tmo = exp_timeout(ch, wstrb, rdy, rv);
            pulse_clear();
            run_access(instr, addr, wdata, wstrb, rdy, rv, rdat);
            checks++; if (m_valid_or !== ((ch < int'(NCh)) ? 3'(1 << ch) : 3'b000)) begin failures++;
                $display("FAIL rnd%0d_route got=%0b exp_ch=%0d", n, m_valid_or, ch); end
            checks++; if (m_lat != exp_lat(ch, wstrb, rdy, rv) || m_ready_cyc != 1) begin failures++;
                $display("FAIL rnd%0d_lat got=%0d/%0d exp=%0d/1", n, m_lat, m_ready_cyc,
                         exp_lat(ch, wstrb, rdy, rv)); end
            checks++; if (m_stable !== 1'b1) begin failures++; $display("FAIL rnd%0d_fields got=unstable exp=stable", n); end
            checks++; if (m_err !== (ch >= int'(NCh) || tmo)) begin failures++;
                $display("FAIL rnd%0d_err got=%0b exp=%0b", n, m_err, ch >= int'(NCh) || tmo); end
            if (wstrb == 4'h0 || ch >= int'(NCh)) begin
                checks++; if (m_rdata !== ((ch >= int'(NCh) || tmo) ? 32'h0 : rdat)) begin failures++;
                    $display("FAIL rnd%0d_rdata got=%0h exp=%0h", n, m_rdata, rdat); end
            end
        end
    endtask

    initial begin
        arst = 1'b1; cke = 1'b1; cpu_valid = 1'b0; cpu_instr = 1'b0; err_clr = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        ch_ready = '0; ch_rvalid = '0; ch_rdata = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_read_basic();
        test_write_wait();
        test_instr_fetch();
        test_unmapped();
        test_timeout();
        test_cke();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
